// File: rtl/ddr_vector_packer_if.sv
// Stream bundle between the DDR read path, the vector packer and the kNN
// distance stage. The beat side (S_*) carries single dimensions in, the
// vector side (M_*) carries packed feature vectors out.
interface ddr_vector_packer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DIMS   = 4,
    parameter int CNT_WIDTH  = 16
);

    logic [DATA_WIDTH-1:0]          S_DATA;
    logic                           S_VALID;
    logic                           S_READY;
    logic                           S_LAST;

    logic [NUM_DIMS*DATA_WIDTH-1:0] M_DATA;
    logic [CNT_WIDTH-1:0]           M_INDEX;
    logic                           M_VALID;
    logic                           M_READY;

    // Environment view: produces beats and consumes vectors.
    modport master (
        output S_DATA,
        output S_VALID,
        output S_LAST,
        input  S_READY,
        input  M_DATA,
        input  M_INDEX,
        input  M_VALID,
        output M_READY
    );

    // Packer view: consumes beats and produces vectors.
    modport slave (
        input  S_DATA,
        input  S_VALID,
        input  S_LAST,
        output S_READY,
        output M_DATA,
        output M_INDEX,
        output M_VALID,
        input  M_READY
    );

endinterface

// File: rtl/ddr_vector_packer.sv
// Packs NUM_DIMS consecutive 32-bit DDR read beats into one feature vector,
// buffers vectors in a small FIFO and streams them to the kNN distance stage.
// A START/BUSY/DONE/ERROR handshake frames each job of NUM_VECTORS vectors.
// ERROR is a sticky flag raised when a read burst ends part-way through a
// vector; packing carries on with that beat regardless.
module ddr_vector_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DIMS   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 START,
    input  logic [CNT_WIDTH-1:0] NUM_VECTORS,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERROR,
    ddr_vector_packer_if.slave   bus
);

    localparam int VEC_WIDTH = NUM_DIMS * DATA_WIDTH;
    localparam int DIM_W     = $clog2(NUM_DIMS);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int FCNT_W    = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIM_W-1:0]  LAST_DIM   = DIM_W'(NUM_DIMS - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL  = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        DRAIN,
        FINISH
    } state_t;

    // Reset synchronizer outputs
    logic [1:0]           rst_pipe;
    logic                 rst;

    // Control state
    state_t               state;
    state_t               next_state;
    logic [CNT_WIDTH-1:0] num_vec;
    logic [DIM_W-1:0]     dim_cnt;
    logic [CNT_WIDTH-1:0] vec_in_cnt;
    logic [CNT_WIDTH-1:0] vec_out_cnt;
    logic                 error_q;
    logic                 done_q;

    // Packing register, one lane per dimension
    logic [DATA_WIDTH-1:0] lane_q [NUM_DIMS];
    logic [VEC_WIDTH-1:0]  packed_vec;

    // Vector FIFO
    logic [VEC_WIDTH-1:0] data_mem  [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0] index_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [FCNT_W-1:0]    fifo_count;

    // Handshake decodes
    logic start_ok;
    logic s_ready;
    logic beat_fire;
    logic last_dim;
    logic push;
    logic pop;
    logic fifo_valid;
    logic job_fed;

    // Reset asserts immediately but is released two clock edges later so
    // every flop leaves reset on the same edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end

    assign rst = rst_pipe[1];

    // Beat acceptance depends only on registered state; a pop in the same
    // cycle does not open the input, which keeps S_READY off the M_READY path.
    assign start_ok   = (state == IDLE) && START;
    assign s_ready    = (state == PACK) && (fifo_count < FIFO_FULL);
    assign beat_fire  = s_ready && bus.S_VALID;
    assign last_dim   = (dim_cnt == LAST_DIM);
    assign push       = beat_fire && last_dim;
    assign fifo_valid = (fifo_count != '0);
    assign pop        = fifo_valid && bus.M_READY;
    assign job_fed    = push && ((vec_in_cnt + CNT_WIDTH'(1)) == num_vec);

    // Assemble the outgoing vector: finished lanes from the register plus the
    // beat arriving now in the lane it is destined for.
    always_comb begin
        packed_vec = '0;
        for (int i = 0; i < NUM_DIMS; i++) begin
            if (dim_cnt == DIM_W'(i)) begin
                packed_vec[i*DATA_WIDTH +: DATA_WIDTH] = bus.S_DATA;
            end else begin
                packed_vec[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
            end
        end
    end

    // Job sequencing: feed vectors, wait for the consumer to drain, then pulse DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (START) begin
                    next_state = (NUM_VECTORS == '0) ? FINISH : PACK;
                end
            end
            PACK: begin
                if (job_fed) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (vec_out_cnt == num_vec) begin
                    next_state = FINISH;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register, job counters, sticky error flag and the DONE pulse.
    always_ff @(posedge ACLK or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            num_vec     <= '0;
            dim_cnt     <= '0;
            vec_in_cnt  <= '0;
            vec_out_cnt <= '0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= (state == FINISH);
            if (start_ok) begin
                num_vec     <= NUM_VECTORS;
                dim_cnt     <= '0;
                vec_in_cnt  <= '0;
                vec_out_cnt <= '0;
                error_q     <= 1'b0;
            end else begin
                if (beat_fire) begin
                    dim_cnt <= last_dim ? '0 : dim_cnt + DIM_W'(1);
                    if (bus.S_LAST && !last_dim) begin
                        error_q <= 1'b1;
                    end
                end
                if (push) begin
                    vec_in_cnt <= vec_in_cnt + CNT_WIDTH'(1);
                end
                if (pop) begin
                    vec_out_cnt <= vec_out_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Capture each accepted beat into its dimension lane.
    always_ff @(posedge ACLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIMS; i++) begin
                lane_q[i] <= '0;
            end
        end else if (beat_fire) begin
            lane_q[dim_cnt] <= bus.S_DATA;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge ACLK or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents are only observed through a valid head, so no reset.
    always_ff @(posedge ACLK) begin
        if (push) begin
            data_mem[wr_ptr]  <= packed_vec;
            index_mem[wr_ptr] <= vec_in_cnt;
        end
    end

    assign bus.S_READY = s_ready;
    assign bus.M_VALID = fifo_valid;
    assign bus.M_DATA  = fifo_valid ? data_mem[rd_ptr]  : '0;
    assign bus.M_INDEX = fifo_valid ? index_mem[rd_ptr] : '0;
    assign BUSY        = (state != IDLE);
    assign DONE        = done_q;
    assign ERROR       = error_q;

endmodule

// File: tb/tb_ddr_vector_packer.sv
// Directed bench for ddr_vector_packer. Expected vectors are queued when the
// stimulus is planned; a monitor pops them whenever a vector is handed over.
module tb_ddr_vector_packer;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  index;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        START = 1'b0;
    logic [15:0] NUM_VECTORS = '0;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;

    int checks = 0;
    int passes = 0;
    int done_count = 0;
    exp_t exp_q[$];

    ddr_vector_packer_if #(.DATA_WIDTH(32), .NUM_DIMS(4), .CNT_WIDTH(16)) bus ();

    ddr_vector_packer #(
        .DATA_WIDTH(32),
        .NUM_DIMS  (4),
        .FIFO_DEPTH(4),
        .CNT_WIDTH (16)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .START      (START),
        .NUM_VECTORS(NUM_VECTORS),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERROR      (ERROR),
        .bus        (bus)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    function automatic exp_t makeVec(input logic [31:0] base, input logic [15:0] idx);
        exp_t e;
        e.data = '0;
        for (int d = 0; d < 4; d++) begin
            e.data[d*32 +: 32] = base + 32'(d);
        end
        e.index = idx;
        return e;
    endfunction

    // Present one beat and hold it until accepted (bounded wait).
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        int wait_cycles = 0;
        bus.S_DATA  = data;
        bus.S_LAST  = last;
        bus.S_VALID = 1'b1;
        @(negedge ACLK);
        while (!bus.S_READY && wait_cycles < 200) begin
            @(negedge ACLK);
            wait_cycles++;
        end
        if (!bus.S_READY) begin
            checks++;
            $display("[TB] FAIL beat_accept: S_READY stayed 0 for beat %h, required 1", data);
        end
        @(posedge ACLK);
        #1;
        bus.S_VALID = 1'b0;
        bus.S_LAST  = 1'b0;
    endtask

    task automatic startJob(input logic [15:0] n);
        START       = 1'b1;
        NUM_VECTORS = n;
        @(posedge ACLK);
        #1;
        START = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        @(negedge ACLK);
        while (!DONE && n < budget) begin
            @(negedge ACLK);
            n++;
        end
        checkOutput({name, "_done"}, 128'(DONE), 128'(1));
        checkOutput({name, "_busy_at_done"}, 128'(BUSY), 128'(0));
        @(negedge ACLK);
        checkOutput({name, "_done_single"}, 128'(DONE), 128'(0));
        @(posedge ACLK);
        #1;
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, "_s_ready"}, 128'(bus.S_READY), 128'(0));
        checkOutput({name, "_m_valid"}, 128'(bus.M_VALID), 128'(0));
        checkOutput({name, "_busy"},    128'(BUSY),        128'(0));
        checkOutput({name, "_done"},    128'(DONE),        128'(0));
        checkOutput({name, "_error"},   128'(ERROR),       128'(0));
        checkOutput({name, "_m_data"},  128'(bus.M_DATA),  128'(0));
        checkOutput({name, "_m_index"}, 128'(bus.M_INDEX), 128'(0));
    endtask

    // Scoreboard monitor: every handed-over vector must match the queue head.
    always @(negedge ACLK) begin
        if (!ARESET && bus.M_VALID && bus.M_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_vector: got index %0d, required no vector", bus.M_INDEX);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("vector_data",  128'(bus.M_DATA),  e.data);
                checkOutput("vector_index", 128'(bus.M_INDEX), 128'(e.index));
            end
        end
        if (DONE) begin
            done_count++;
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.S_DATA  = '0;
        bus.S_VALID = 1'b0;
        bus.S_LAST  = 1'b0;
        bus.M_READY = 1'b0;

        // Reset state
        #12;
        checkIdleOutputs("reset");
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        repeat (4) @(posedge ACLK);
        #1;

        // Test 1: two vectors, consumer always ready
        $display("[TB] test 1: basic packing");
        bus.M_READY = 1'b1;
        begin
            exp_t e;
            e.data = 128'h00000004_00000003_00000002_00000001; e.index = 16'd0; exp_q.push_back(e);
            e.data = 128'h00000008_00000007_00000006_00000005; e.index = 16'd1; exp_q.push_back(e);
        end
        startJob(16'd2);
        checkOutput("t1_busy", 128'(BUSY), 128'(1));
        for (int b = 1; b <= 8; b++) begin
            applyStimulus(32'(b), b == 8);
        end
        waitDone("t1", 50);
        checkOutput("t1_error", 128'(ERROR), 128'(0));
        checkOutput("t1_sb_empty", 128'(exp_q.size()), 128'(0));

        // Test 2: back-pressure fills the FIFO, then drains in order
        $display("[TB] test 2: back-pressure");
        bus.M_READY = 1'b0;
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(makeVec(32'h100 + 32'(4*v), 16'(v)));
        end
        startJob(16'd6);
        for (int b = 0; b < 16; b++) begin
            applyStimulus(32'h100 + 32'(b), 1'b0);
        end
        @(negedge ACLK);
        checkOutput("t2_s_ready_full", 128'(bus.S_READY), 128'(0));
        checkOutput("t2_m_valid_full", 128'(bus.M_VALID), 128'(1));
        checkOutput("t2_head_index",   128'(bus.M_INDEX), 128'(0));
        @(posedge ACLK);
        #1;
        bus.M_READY = 1'b1;
        for (int b = 16; b < 24; b++) begin
            applyStimulus(32'h100 + 32'(b), 1'b0);
        end
        waitDone("t2", 100);
        checkOutput("t2_sb_empty", 128'(exp_q.size()), 128'(0));

        // Test 3: burst ends mid-vector
        $display("[TB] test 3: misaligned burst");
        exp_q.push_back(makeVec(32'h11, 16'd0));
        exp_q.push_back(makeVec(32'h15, 16'd1));
        startJob(16'd2);
        for (int b = 0; b < 8; b++) begin
            applyStimulus(32'h11 + 32'(b), b == 2);
            if (b == 1) checkOutput("t3_error_before", 128'(ERROR), 128'(0));
            if (b == 2) checkOutput("t3_error_set", 128'(ERROR), 128'(1));
        end
        waitDone("t3", 50);
        checkOutput("t3_error_sticky", 128'(ERROR), 128'(1));
        exp_q.push_back(makeVec(32'h21, 16'd0));
        startJob(16'd1);
        checkOutput("t3_error_cleared", 128'(ERROR), 128'(0));
        for (int b = 0; b < 4; b++) begin
            applyStimulus(32'h21 + 32'(b), b == 3);
        end
        waitDone("t3b", 50);
        checkOutput("t3_sb_empty", 128'(exp_q.size()), 128'(0));

        // Test 4: empty job
        $display("[TB] test 4: zero vectors");
        startJob(16'd0);
        @(negedge ACLK);
        checkOutput("t4_done_c1",    128'(DONE),        128'(0));
        checkOutput("t4_busy_c1",    128'(BUSY),        128'(1));
        checkOutput("t4_s_ready_c1", 128'(bus.S_READY), 128'(0));
        @(negedge ACLK);
        checkOutput("t4_done_c2",    128'(DONE),        128'(1));
        checkOutput("t4_busy_c2",    128'(BUSY),        128'(0));
        checkOutput("t4_s_ready_c2", 128'(bus.S_READY), 128'(0));
        @(negedge ACLK);
        checkOutput("t4_done_c3",    128'(DONE),        128'(0));
        @(posedge ACLK);
        #1;

        // Test 5: reset in the middle of a job
        $display("[TB] test 5: reset mid-job");
        exp_q.push_back(makeVec(32'h31, 16'd0));
        startJob(16'd3);
        for (int b = 0; b < 5; b++) begin
            applyStimulus(32'h31 + 32'(b), 1'b0);
        end
        checkOutput("t5_sb_empty_pre", 128'(exp_q.size()), 128'(0));
        begin
            int done_before;
            done_before = done_count;
            ARESET = 1'b1;
            #1;
            checkIdleOutputs("t5_reset");
            repeat (3) @(posedge ACLK);
            #1;
            ARESET = 1'b0;
            repeat (4) @(posedge ACLK);
            #1;
            checkOutput("t5_no_done", 128'(done_count), 128'(done_before));
        end
        exp_q.push_back(makeVec(32'h41, 16'd0));
        startJob(16'd1);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(32'h41 + 32'(b), 1'b0);
        end
        waitDone("t5", 50);
        checkOutput("t5_sb_empty", 128'(exp_q.size()), 128'(0));

        // Test 6: START while busy is ignored
        $display("[TB] test 6: START while busy");
        exp_q.push_back(makeVec(32'h51, 16'd0));
        exp_q.push_back(makeVec(32'h55, 16'd1));
        startJob(16'd2);
        applyStimulus(32'h51, 1'b0);
        applyStimulus(32'h52, 1'b0);
        startJob(16'd5);
        checkOutput("t6_busy_after_restart", 128'(BUSY), 128'(1));
        for (int b = 2; b < 8; b++) begin
            applyStimulus(32'h51 + 32'(b), 1'b0);
        end
        waitDone("t6", 50);
        checkOutput("t6_sb_empty", 128'(exp_q.size()), 128'(0));
        checkOutput("t6_idle_s_ready", 128'(bus.S_READY), 128'(0));

        checkOutput("done_total", 128'(done_count), 128'(7));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
